iob2axi_burst_split: RTL and testbench

Burst-planning stage that sits directly upstream of the AXI read and write engines (`iob2axi_rd` / `iob2axi_wr`). It accepts one transfer request (start address plus total beat count) and emits a sequence of AXI4-legal bursts, one at a time. Each burst stays inside a single 4 KB page and carries at most 256 beats. The engine in use consumes each burst and reports completion. This block advances the address, decrements the remaining count, and signals overall completion or error.

---
 rtl/iob2axi_burst_split_pkg.sv | 16 +
 rtl/iob2axi_burst_calc.sv | 30 +++
 rtl/iob2axi_burst_split.sv | 107 ++++++++++
 tb/tb_iob2axi_burst_split.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob2axi_burst_split_pkg.sv
// Shared AXI burst constants and helpers.
// Used by the burst planner and its calc stage.
package iob2axi_burst_split_pkg;

  localparam int AXI_LEN_W     = 8;
  localparam int AXI_MAX_BEATS = 256;
  localparam int AXI_4K_BYTES  = 4096;

  function automatic logic [12:0] min13(
    input logic [12:0] a,
    input logic [12:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/iob2axi_burst_calc.sv
// Burst size calc: beats left before the 4 KB
// page edge, capped by remaining and 256.
module iob2axi_burst_calc
  import iob2axi_burst_split_pkg::*;
#(
  parameter int TLEN_W = 16,
  parameter int BYTES  = 4
) (
  input  logic [11:0]       cur_addr,
  input  logic [TLEN_W-1:0] remaining,
  output logic [12:0]       beats
);

  localparam int LOG2B = $clog2(BYTES);

  logic [12:0] off;
  logic [12:0] to4k;
  logic [12:0] rem_c;

  // page room and length cap, 13-bit arithmetic
  always_comb begin
    off   = {1'b0, cur_addr};
    to4k  = (13'(AXI_4K_BYTES) - off) >> LOG2B;
    rem_c = (remaining >= TLEN_W'(AXI_MAX_BEATS))
          ? 13'(AXI_MAX_BEATS)
          : 13'(remaining);
    beats = min13(rem_c, to4k);
  end

endmodule

// File: rtl/iob2axi_burst_split.sv
// Splits a transfer into AXI bursts that stay
// inside a 4 KB page and carry <= 256 beats.
module iob2axi_burst_split
  import iob2axi_burst_split_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int TLEN_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [TLEN_W-1:0]     length,
  output logic                  ready,
  output logic                  error,
  output logic                  burst_valid,
  output logic [AXI_ADDR_W-1:0] burst_addr,
  output logic [AXI_LEN_W-1:0]  burst_len,
  input  logic                  burst_ready,
  input  logic                  burst_done,
  input  logic                  burst_error
);

  localparam int BYTES = AXI_DATA_W / 8;
  localparam int LOG2B = $clog2(BYTES);
  localparam logic [AXI_ADDR_W-1:0] AMASK =
    ~AXI_ADDR_W'(BYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]            state;
  logic [AXI_ADDR_W-1:0] cur_addr;
  logic [TLEN_W-1:0]     remaining;
  logic [12:0]           beats;
  logic [12:0]           beats_q;

  iob2axi_burst_calc #(
    .TLEN_W (TLEN_W),
    .BYTES  (BYTES)
  ) u_calc (
    .cur_addr  (cur_addr[11:0]),
    .remaining (remaining),
    .beats     (beats)
  );

  assign ready       = (state == IDLE);
  assign burst_valid = (state == ISSUE);

  // planner FSM: latch, size, issue, await done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      beats_q    <= '0;
      burst_addr <= '0;
      burst_len  <= '0;
      error      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) begin
            error <= 1'b0;
            if (length != '0) begin
              cur_addr  <= addr & AMASK;
              remaining <= length;
              state     <= CALC;
            end
          end
        end
        CALC: begin
          burst_addr <= cur_addr;
          burst_len  <= AXI_LEN_W'(beats - 13'd1);
          beats_q    <= beats;
          state      <= ISSUE;
        end
        ISSUE: begin
          if (burst_ready) begin
            cur_addr <= cur_addr +
              (AXI_ADDR_W'(beats_q) << LOG2B);
            remaining <= remaining -
              TLEN_W'(beats_q);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (burst_done) begin
            if (burst_error) begin
              error <= 1'b1;
              state <= IDLE;
            end else if (remaining == '0) begin
              state <= IDLE;
            end else begin
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob2axi_burst_split.sv
// Directed bench for iob2axi_burst_split
// with a simple hand-driven engine.
module tb_iob2axi_burst_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] addr;
  logic [15:0] length;
  logic        ready;
  logic        error;
  logic        burst_valid;
  logic [31:0] burst_addr;
  logic [7:0]  burst_len;
  logic        burst_ready;
  logic        burst_done;
  logic        burst_error;

  int checks = 0;
  int errors = 0;

  iob2axi_burst_split dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .addr        (addr),
    .length      (length),
    .ready       (ready),
    .error       (error),
    .burst_valid (burst_valid),
    .burst_addr  (burst_addr),
    .burst_len   (burst_len),
    .burst_ready (burst_ready),
    .burst_done  (burst_done),
    .burst_error (burst_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input logic [31:0] a, input logic [15:0] l);
    run = 1'b1;
    addr = a;
    length = l;
    step();
    run = 1'b0;
  endtask

  task automatic take_burst(output logic [31:0] a, output logic [7:0] l,
                            output bit to);
    to = 1'b1;
    a = '0;
    l = '0;
    for (int i = 0; i < 40; i++) begin
      if (burst_valid) begin
        to = 1'b0;
        break;
      end
      step();
    end
    if (!to) begin
      a = burst_addr;
      l = burst_len;
      burst_ready = 1'b1;
      step();
      burst_ready = 1'b0;
    end
  endtask

  task automatic finish_burst(input bit e);
    burst_done = 1'b1;
    burst_error = e;
    step();
    burst_done = 1'b0;
    burst_error = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (ready !== 1'b1 || error !== 1'b0 || burst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got r%b e%b v%b exp r1 e0 v0",
               ready, error, burst_valid);
    end
    checks++;
    if (burst_addr !== 32'h0 || burst_len !== 8'h0) begin
      errors++;
      $display("FAIL reset_desc got %h/%h exp 0/0", burst_addr, burst_len);
    end
  endtask

  task automatic test_page_cross();
    logic [31:0] a;
    logic [7:0]  l;
    bit          to;
    do_run(32'h0FF0, 16'd10);
    checks++;
    if (ready !== 1'b0 || burst_valid !== 1'b0) begin
      errors++;
      $display("FAIL pc_n1 got r%b v%b exp r0 v0", ready, burst_valid);
    end
    step();
    checks++;
    if (burst_valid !== 1'b1) begin
      errors++;
      $display("FAIL pc_latency got v%b exp v1", burst_valid);
    end
    take_burst(a, l, to);
    checks++;
    if (to || a !== 32'h0FF0 || l !== 8'd3) begin
      errors++;
      $display("FAIL pc_b0 got to%0d %h/%0d exp 00000ff0/3", to, a, l);
    end
    finish_burst(1'b0);
    checks++;
    if (burst_valid !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL pc_m1 got v%b r%b exp v0 r0", burst_valid, ready);
    end
    step();
    checks++;
    if (burst_valid !== 1'b1) begin
      errors++;
      $display("FAIL pc_m2 got v%b exp v1", burst_valid);
    end
    take_burst(a, l, to);
    checks++;
    if (to || a !== 32'h1000 || l !== 8'd5) begin
      errors++;
      $display("FAIL pc_b1 got to%0d %h/%0d exp 00001000/5", to, a, l);
    end
    finish_burst(1'b0);
    checks++;
    if (ready !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL pc_end got r%b e%b exp r1 e0", ready, error);
    end
  endtask

  task automatic test_cap();
    logic [31:0] a;
    logic [7:0]  l;
    bit          to;
    logic [31:0] ea [3];
    logic [7:0]  el [3];
    ea[0] = 32'h000; el[0] = 8'd255;
    ea[1] = 32'h400; el[1] = 8'd255;
    ea[2] = 32'h800; el[2] = 8'd87;
    do_run(32'h0, 16'd600);
    for (int i = 0; i < 3; i++) begin
      take_burst(a, l, to);
      checks++;
      if (to || a !== ea[i] || l !== el[i]) begin
        errors++;
        $display("FAIL cap_b%0d got to%0d %h/%0d exp %h/%0d",
                 i, to, a, l, ea[i], el[i]);
      end
      finish_burst(1'b0);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL cap_end got r%b exp r1", ready);
    end
  endtask

  task automatic test_zero_misalign();
    logic [31:0] a;
    logic [7:0]  l;
    bit          to;
    bit          bad;
    do_run(32'h40, 16'd0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (burst_valid !== 1'b0 || ready !== 1'b1) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL zero_len got v%b r%b exp v0 r1", burst_valid, ready);
    end
    do_run(32'h3, 16'd1);
    take_burst(a, l, to);
    checks++;
    if (to || a !== 32'h0 || l !== 8'd0) begin
      errors++;
      $display("FAIL misalign got to%0d %h/%0d exp 00000000/0", to, a, l);
    end
    finish_burst(1'b0);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL misalign_end got r%b exp r1", ready);
    end
  endtask

  task automatic test_error_abort();
    logic [31:0] a;
    logic [7:0]  l;
    bit          to;
    bit          bad;
    do_run(32'h0, 16'd600);
    take_burst(a, l, to);
    finish_burst(1'b0);
    take_burst(a, l, to);
    checks++;
    if (to || a !== 32'h400 || l !== 8'd255) begin
      errors++;
      $display("FAIL err_b1 got to%0d %h/%0d exp 00000400/255", to, a, l);
    end
    finish_burst(1'b1);
    checks++;
    if (error !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL err_flag got e%b r%b exp e1 r1", error, ready);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (burst_valid !== 1'b0 || error !== 1'b1) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL err_no_b2 got v%b e%b exp v0 e1", burst_valid, error);
    end
    do_run(32'h2000, 16'd1);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got e%b exp e0", error);
    end
    take_burst(a, l, to);
    checks++;
    if (to || a !== 32'h2000 || l !== 8'd0) begin
      errors++;
      $display("FAIL err_after got to%0d %h/%0d exp 00002000/0", to, a, l);
    end
    finish_burst(1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic [7:0]  l;
    bit          to;
    bit          bad;
    bit          seen;
    do_run(32'h100, 16'd300);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (burst_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_timeout got v%b exp v1", burst_valid);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      burst_done = (i == 2);
      step();
      if (burst_valid !== 1'b1 || burst_addr !== 32'h100 ||
          burst_len !== 8'd255) bad = 1'b1;
    end
    burst_done = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_stable got v%b %h/%0d exp v1 00000100/255",
               burst_valid, burst_addr, burst_len);
    end
    take_burst(a, l, to);
    do_run(32'h5000, 16'd7);
    checks++;
    if (ready !== 1'b0 || burst_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_run_ign got r%b v%b exp r0 v0", ready, burst_valid);
    end
    finish_burst(1'b0);
    take_burst(a, l, to);
    checks++;
    if (to || a !== 32'h500 || l !== 8'd43) begin
      errors++;
      $display("FAIL bp_b1 got to%0d %h/%0d exp 00000500/43", to, a, l);
    end
    finish_burst(1'b0);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_end got r%b exp r1", ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    logic [7:0]  l;
    bit          to;
    do_run(32'h0, 16'd600);
    take_burst(a, l, to);
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || burst_valid !== 1'b0 || error !== 1'b0 ||
        burst_addr !== 32'h0 || burst_len !== 8'h0) begin
      errors++;
      $display("FAIL rst_mid got r%b v%b e%b %h/%h exp r1 v0 e0 0/0",
               ready, burst_valid, error, burst_addr, burst_len);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (ready !== 1'b1 || burst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold got r%b v%b exp r1 v0", ready, burst_valid);
    end
    do_run(32'h0FF0, 16'd10);
    take_burst(a, l, to);
    checks++;
    if (to || a !== 32'h0FF0 || l !== 8'd3) begin
      errors++;
      $display("FAIL rst_b0 got to%0d %h/%0d exp 00000ff0/3", to, a, l);
    end
    finish_burst(1'b0);
    take_burst(a, l, to);
    checks++;
    if (to || a !== 32'h1000 || l !== 8'd5) begin
      errors++;
      $display("FAIL rst_b1 got to%0d %h/%0d exp 00001000/5", to, a, l);
    end
    finish_burst(1'b0);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_end got r%b exp r1", ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    addr = '0;
    length = '0;
    burst_ready = 1'b0;
    burst_done = 1'b0;
    burst_error = 1'b0;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_reset();
    test_page_cross();
    test_cap();
    test_zero_misalign();
    test_error_abort();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
